// File: rtl/bus_pkg.sv
// B-bus register decode codes and the auto-joypad sequencer state encoding.
// Shared by hvint, autojoy and the CPU register decoder.
package bus_pkg;

  typedef enum logic [4:0] {
    A_NONE,
    A_NMITIMEN,
    A_JOYWR,
    A_JOYSER0,
    A_JOYSER1,
    A_JOY1L,
    A_JOY1H,
    A_JOY2L,
    A_JOY2H,
    A_JOY3L,
    A_JOY3H,
    A_JOY4L,
    A_JOY4H
  } a_op_type;

  typedef enum logic [2:0] {
    IDLE,
    LATCH_HI,
    LATCH_LO,
    BIT_LO,
    BIT_HI
  } autojoy_state_t;

  localparam int JOY_BITS  = 16;
  localparam int JOY_PORTS = 2;

endpackage

// File: rtl/joy_port_shift.sv
// Per-port pad shifters: D0 feeds JOY1/JOY2, D1 feeds JOY3/JOY4.
// The D1 shifter only exists when AUTOJOY_MULTITAP_EN is defined.
module joy_port_shift
  import bus_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_shift,
  input  logic [1:0]          i_data,
  output logic [JOY_BITS-1:0] o_d0,
  output logic [JOY_BITS-1:0] o_d1
);

  logic [JOY_BITS-1:0] r_d0;

  // Pad lines are active-low; the registers hold 1 = pressed.
  always_ff @(posedge clk) begin
    if (reset)        r_d0 <= '0;
    else if (i_shift) r_d0 <= {r_d0[JOY_BITS-2:0], ~i_data[0]};
  end
  assign o_d0 = r_d0;

`ifdef AUTOJOY_MULTITAP_EN
  logic [JOY_BITS-1:0] r_d1;

  always_ff @(posedge clk) begin
    if (reset)        r_d1 <= '0;
    else if (i_shift) r_d1 <= {r_d1[JOY_BITS-2:0], ~i_data[1]};
  end
  assign o_d1 = r_d1;
`else
  logic w_unused_d1;
  assign w_unused_d1 = i_data[1];
  assign o_d1        = '0;
`endif

endmodule

// File: rtl/autojoy.sv
// Auto-joypad read sequencer plus manual JOYWR/JOYSERn serial access.
// Define AUTOJOY_MULTITAP_EN to capture the D1 lines into JOY3/JOY4.
module autojoy
  import bus_pkg::*;
#(
  parameter int STEP_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_en,
  input  a_op_type   a_op,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       vblank,
  input  logic [1:0] joy_data1,
  input  logic [1:0] joy_data2,
  output logic       joy_latch,
  output logic       joy_clk1,
  output logic       joy_clk2,
  output logic       auto_busy
);

  localparam int SW = $clog2(STEP_CYCLES + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  autojoy_state_t r_state;
  logic [SW-1:0]  r_step;
  logic [3:0]     r_bit_cnt;
  logic           r_fsm_latch;
  logic           r_fsm_clk;
  logic           r_vblank_prev;
  logic           r_auto_en;
  logic           r_man_latch;
  logic           r_man_clk1;
  logic           r_man_clk2;

  logic w_start;
  logic w_last;
  logic w_shift;
  logic w_ser1_hi;
  logic w_ser2_hi;

  logic [JOY_PORTS-1:0][1:0]          w_pad;
  logic [JOY_PORTS-1:0][JOY_BITS-1:0] w_d0;
  logic [JOY_PORTS-1:0][JOY_BITS-1:0] w_d1;

  assign w_start = vblank & ~r_vblank_prev & r_auto_en & (r_state == IDLE);
  assign w_last  = (r_step == STEP_LAST);
  assign w_shift = (r_state == BIT_LO) && (r_step == '0);

  // CPU-side registers; a JOYSER read strobes that port's clock low for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vblank_prev <= 1'b0;
      r_auto_en     <= 1'b0;
      r_man_latch   <= 1'b0;
      r_man_clk1    <= 1'b1;
      r_man_clk2    <= 1'b1;
    end else begin
      r_vblank_prev <= vblank;
      r_man_clk1    <= ~(cpu_en && a_op == A_JOYSER0);
      r_man_clk2    <= ~(cpu_en && a_op == A_JOYSER1);
      if (cpu_en && a_op == A_NMITIMEN) r_auto_en   <= wdata[0];
      if (cpu_en && a_op == A_JOYWR)    r_man_latch <= wdata[0];
    end
  end

  // Sequencer: every state lasts STEP_CYCLES; latch and clock are registered
  // alongside the state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_step      <= '0;
      r_bit_cnt   <= '0;
      r_fsm_latch <= 1'b0;
      r_fsm_clk   <= 1'b1;
    end else begin
      r_step <= w_last ? '0 : r_step + 1'b1;
      case (r_state)
        IDLE: begin
          r_step <= '0;
          if (w_start) begin
            r_state     <= LATCH_HI;
            r_bit_cnt   <= '0;
            r_fsm_latch <= 1'b1;
          end
        end
        LATCH_HI: if (w_last) begin
          r_state     <= LATCH_LO;
          r_fsm_latch <= 1'b0;
        end
        LATCH_LO: if (w_last) begin
          r_state   <= BIT_LO;
          r_fsm_clk <= 1'b0;
        end
        BIT_LO: if (w_last) begin
          r_state   <= BIT_HI;
          r_fsm_clk <= 1'b1;
        end
        BIT_HI: if (w_last) begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == 4'd15) begin
            r_state <= IDLE;
          end else begin
            r_state   <= BIT_LO;
            r_fsm_clk <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_fsm_latch <= 1'b0;
          r_fsm_clk   <= 1'b1;
        end
      endcase
    end
  end

  assign w_pad = {joy_data2, joy_data1};

  for (genvar gp = 0; gp < JOY_PORTS; gp++) begin : g_port
    joy_port_shift u_shift (
      .clk     (clk),
      .reset   (reset),
      .i_shift (w_shift),
      .i_data  (w_pad[gp]),
      .o_d0    (w_d0[gp]),
      .o_d1    (w_d1[gp])
    );
  end

`ifdef AUTOJOY_MULTITAP_EN
  assign w_ser1_hi = ~joy_data1[1];
  assign w_ser2_hi = ~joy_data2[1];
`else
  assign w_ser1_hi = 1'b0;
  assign w_ser2_hi = 1'b0;
`endif

  always_comb begin
    rdata = 8'h00;
    case (a_op)
      A_JOYSER0: rdata = {6'h0, w_ser1_hi, ~joy_data1[0]};
      A_JOYSER1: rdata = {6'h0, w_ser2_hi, ~joy_data2[0]};
      A_JOY1L:   rdata = w_d0[0][7:0];
      A_JOY1H:   rdata = w_d0[0][15:8];
      A_JOY2L:   rdata = w_d0[1][7:0];
      A_JOY2H:   rdata = w_d0[1][15:8];
      A_JOY3L:   rdata = w_d1[0][7:0];
      A_JOY3H:   rdata = w_d1[0][15:8];
      A_JOY4L:   rdata = w_d1[1][7:0];
      A_JOY4H:   rdata = w_d1[1][15:8];
      default:   rdata = 8'h00;
    endcase
  end

  assign joy_latch = r_man_latch | r_fsm_latch;
  assign joy_clk1  = r_fsm_clk & r_man_clk1;
  assign joy_clk2  = r_fsm_clk & r_man_clk2;
  assign auto_busy = (r_state != IDLE);

endmodule

// File: tb/tb_autojoy.sv
// Randomized bench for autojoy: behavioural pads that shift out button words
// on latch/clock edges, with a queue-based scoreboard checked by a monitor.
module tb_autojoy;
  import bus_pkg::*;

  localparam int STEP   = 2;
  localparam int RD_LEN = 34 * STEP;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_en = 1'b0;
  a_op_type   a_op = A_NONE;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       vblank = 1'b0;
  logic [1:0] joy_data1, joy_data2;
  logic       joy_latch, joy_clk1, joy_clk2, auto_busy;

  always #5 clk = ~clk;

  autojoy #(.STEP_CYCLES(STEP)) dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .a_op(a_op), .wdata(wdata),
    .rdata(rdata), .vblank(vblank), .joy_data1(joy_data1), .joy_data2(joy_data2),
    .joy_latch(joy_latch), .joy_clk1(joy_clk1), .joy_clk2(joy_clk2),
    .auto_busy(auto_busy)
  );

  // ---------------- pad model: button word, MSB shifted out first ----------
  logic [15:0] btn1 = 16'h0, btn2 = 16'h0;
  logic        d1a = 1'b1, d1b = 1'b1;
  int          idx1 = 15, idx2 = 15;
  logic        man_mode = 1'b0;
  logic [1:0]  man_d1 = 2'b11, man_d2 = 2'b11;

  function automatic logic padbit(input logic [15:0] b, input int idx);
    return (idx >= 0 && idx <= 15) ? ~b[idx] : 1'b0;
  endfunction

  initial forever begin
    @(posedge joy_clk1 or posedge joy_latch);
    if (joy_latch === 1'b1) idx1 = 15; else idx1 = idx1 - 1;
  end
  initial forever begin
    @(posedge joy_clk2 or posedge joy_latch);
    if (joy_latch === 1'b1) idx2 = 15; else idx2 = idx2 - 1;
  end

  assign joy_data1 = man_mode ? man_d1 : {d1a, padbit(btn1, idx1)};
  assign joy_data2 = man_mode ? man_d2 : {d1b, padbit(btn2, idx2)};

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    int          sel;
    logic [15:0] val;
  } chk_t;

  typedef struct {
    int len;
    int p1;
    int p2;
  } rd_t;

  chk_t cq[$];
  rd_t  rq[$];
  logic chk_req = 1'b0;
  logic wait_ok = 1'b0;
  logic aborted = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   lat_pulses = 0;
  int   exp_lat = 0;

  initial begin : monitor
    chk_t        it;
    rd_t         er;
    logic [15:0] act;
    int          blen, p1, p2;
    logic        pbusy, pclk1, pclk2, plat;
    blen = 0; p1 = 0; p2 = 0;
    pbusy = 1'b0; pclk1 = 1'b1; pclk2 = 1'b1; plat = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_busy === 1'b1) blen++;
      if (pclk1 === 1'b1 && joy_clk1 === 1'b0 && auto_busy === 1'b1) p1++;
      if (pclk2 === 1'b1 && joy_clk2 === 1'b0 && auto_busy === 1'b1) p2++;
      if (plat === 1'b0 && joy_latch === 1'b1) lat_pulses++;
      if (pbusy === 1'b1 && auto_busy === 1'b0) begin
        if (!aborted) begin
          tests++;
          if (rq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_read: got busy for %0d cycles, required none", blen);
          end else begin
            er = rq.pop_front();
            if (blen != er.len) begin
              fails++;
              $display("FAIL busy_len: got %0d required %0d", blen, er.len);
            end
            tests++;
            if (p1 != er.p1) begin
              fails++;
              $display("FAIL clk1_pulses: got %0d required %0d", p1, er.p1);
            end
            tests++;
            if (p2 != er.p2) begin
              fails++;
              $display("FAIL clk2_pulses: got %0d required %0d", p2, er.p2);
            end
          end
        end
        blen = 0; p1 = 0; p2 = 0;
      end
      if (chk_req) begin
        tests++;
        if (cq.size() == 0) begin
          fails++;
          $display("FAIL probe: got no queued expectation, required one");
        end else begin
          it = cq.pop_front();
          case (it.sel)
            0:       act = {8'h00, rdata};
            1:       act = {15'h0, joy_latch};
            2:       act = {15'h0, joy_clk1};
            3:       act = {15'h0, joy_clk2};
            4:       act = {15'h0, auto_busy};
            5:       act = 16'(lat_pulses);
            6:       act = 16'(rq.size());
            default: act = {15'h0, wait_ok};
          endcase
          if (act !== it.val) begin
            fails++;
            $display("FAIL %s: got %h required %h", it.name, act, it.val);
          end
        end
      end
      pbusy = auto_busy; pclk1 = joy_clk1; pclk2 = joy_clk2; plat = joy_latch;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic probe(input string n, input int s, input logic [15:0] v);
    cq.push_back('{n, s, v});
    chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
  endtask

  task automatic rd(input string n, input a_op_type op, input logic [7:0] v);
    a_op = op;
    probe(n, 0, {8'h00, v});
    a_op = A_NONE;
  endtask

  task automatic wr(input a_op_type op, input logic [7:0] d);
    a_op = op; wdata = d; cpu_en = 1'b1;
    tick();
    cpu_en = 1'b0; a_op = A_NONE;
  endtask

  task automatic wait_busy(input logic v, input string n);
    wait_ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (auto_busy === v) begin
        wait_ok = 1'b1;
        break;
      end
      tick();
    end
    probe(n, 7, 16'h1);
  endtask

  task automatic check_joy(input logic [15:0] j1, j2, j3, j4);
    rd("joy1l", A_JOY1L, j1[7:0]);  rd("joy1h", A_JOY1H, j1[15:8]);
    rd("joy2l", A_JOY2L, j2[7:0]);  rd("joy2h", A_JOY2H, j2[15:8]);
    rd("joy3l", A_JOY3L, j3[7:0]);  rd("joy3h", A_JOY3H, j3[15:8]);
    rd("joy4l", A_JOY4L, j4[7:0]);  rd("joy4h", A_JOY4H, j4[15:8]);
  endtask

  function automatic logic [15:0] d1_word(input logic lvl);
`ifdef AUTOJOY_MULTITAP_EN
    return lvl ? 16'h0000 : 16'hFFFF;
`else
    return (lvl === 1'bx) ? 16'h0 : 16'h0000;
`endif
  endfunction

  task automatic rise_vblank();
    vblank = 1'b0; tick();
    vblank = 1'b1;
  endtask

  logic [15:0] e1, e2, e3, e4;

  initial begin
    int n;
    logic pc;
    e1 = '0; e2 = '0; e3 = '0; e4 = '0;

    // reset state
    repeat (3) tick();
    reset = 1'b0;
    probe("rst_latch", 1, 16'h0);
    probe("rst_clk1", 2, 16'h1);
    probe("rst_clk2", 3, 16'h1);
    probe("rst_busy", 4, 16'h0);
    check_joy(16'h0, 16'h0, 16'h0, 16'h0);

    // randomized auto-reads
    wr(A_NMITIMEN, 8'h01);
    for (int k = 0; k < 6; k++) begin
      btn1 = (k == 0) ? 16'hFFFF : 16'($urandom);
      btn2 = (k == 0) ? 16'($urandom) : (k == 1) ? 16'h8000 : 16'($urandom);
      d1a  = (k == 0) ? 1'b1 : 1'($urandom);
      d1b  = 1'($urandom);
      rise_vblank();
      rq.push_back('{RD_LEN, 16, 16});
      exp_lat++;
      wait_busy(1'b1, "read_start");
      wait_busy(1'b0, "read_done");
      vblank = 1'b0;
      e1 = btn1; e2 = btn2; e3 = d1_word(d1a); e4 = d1_word(d1b);
      check_joy(e1, e2, e3, e4);
    end
    probe("latch_count", 5, 16'(exp_lat));

    // disabled: no read, registers keep their values
    wr(A_NMITIMEN, 8'h00);
    btn1 = ~e1; btn2 = ~e2;
    rise_vblank();
    repeat (100) tick();
    probe("dis_busy", 4, 16'h0);
    probe("dis_latch_count", 5, 16'(exp_lat));
    check_joy(e1, e2, e3, e4);
    vblank = 1'b0;

    // disable mid-read plus a second vblank rise: completes, no restart
    wr(A_NMITIMEN, 8'h01);
    btn1 = 16'($urandom); btn2 = 16'($urandom);
    rise_vblank();
    rq.push_back('{RD_LEN, 16, 16});
    exp_lat++;
    wait_busy(1'b1, "mid_start");
    repeat (24) tick();
    wr(A_NMITIMEN, 8'h00);
    rise_vblank();
    wait_busy(1'b0, "mid_done");
    repeat (60) tick();
    probe("mid_no_restart", 4, 16'h0);
    e1 = btn1; e2 = btn2;
    check_joy(e1, e2, e3, e4);

    // still enabled, edge while busy is ignored
    wr(A_NMITIMEN, 8'h01);
    btn1 = 16'($urandom); btn2 = 16'($urandom);
    rise_vblank();
    rq.push_back('{RD_LEN, 16, 16});
    exp_lat++;
    wait_busy(1'b1, "ign_start");
    repeat (30) tick();
    rise_vblank();
    wait_busy(1'b0, "ign_done");
    repeat (20) tick();
    probe("ign_no_restart", 4, 16'h0);
    probe("ign_latch_count", 5, 16'(exp_lat));
    e1 = btn1; e2 = btn2;
    rd("ign_joy1h", A_JOY1H, e1[15:8]);
    rd("ign_joy2l", A_JOY2L, e2[7:0]);
    vblank = 1'b0;

    // manual serial access
    wr(A_JOYWR, 8'h01);
    exp_lat++;
    probe("man_latch_hi", 1, 16'h1);
    man_mode = 1'b1;
    man_d1 = 2'b01;
    cpu_en = 1'b1;
`ifdef AUTOJOY_MULTITAP_EN
    rd("joyser0_strobe", A_JOYSER0, 8'h02);
`else
    rd("joyser0_strobe", A_JOYSER0, 8'h00);
`endif
    cpu_en = 1'b0;
    probe("man_clk1_low", 2, 16'h0);
    probe("man_clk1_back", 2, 16'h1);
    man_d1 = 2'b10;
`ifdef AUTOJOY_MULTITAP_EN
    rd("joyser0_peek", A_JOYSER0, 8'h01);
`else
    rd("joyser0_peek", A_JOYSER0, 8'h01);
`endif
    probe("man_clk1_nostrobe", 2, 16'h1);
    man_d2 = 2'b00;
    cpu_en = 1'b1;
`ifdef AUTOJOY_MULTITAP_EN
    rd("joyser1_strobe", A_JOYSER1, 8'h03);
`else
    rd("joyser1_strobe", A_JOYSER1, 8'h01);
`endif
    cpu_en = 1'b0;
    probe("man_clk2_low", 3, 16'h0);
    probe("man_clk2_back", 3, 16'h1);
    wr(A_JOYWR, 8'h00);
    probe("man_latch_lo", 1, 16'h0);
    man_mode = 1'b0;

    // reset during BIT_LO of bit 7
    wr(A_NMITIMEN, 8'h01);
    btn1 = 16'($urandom) | 16'h0100; btn2 = 16'($urandom);
    aborted = 1'b1;
    rise_vblank();
    exp_lat++;
    wait_busy(1'b1, "rst_mid_start");
    n = 0; pc = joy_clk1;
    for (int i = 0; i < 200 && n < 8; i++) begin
      tick();
      if (pc === 1'b1 && joy_clk1 === 1'b0) n++;
      pc = joy_clk1;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ok = (n == 8);
    probe("rst_mid_reached_bit7", 7, 16'h1);
    probe("rst_mid_busy", 4, 16'h0);
    probe("rst_mid_clk1", 2, 16'h1);
    probe("rst_mid_latch", 1, 16'h0);
    check_joy(16'h0, 16'h0, 16'h0, 16'h0);
    aborted = 1'b0;
    rise_vblank();
    repeat (60) tick();
    probe("rst_clears_en", 4, 16'h0);
    probe("final_latch_count", 5, 16'(exp_lat));
    probe("reads_outstanding", 6, 16'h0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/autojoy.md
# autojoy

Auto-joypad read sequencer and serial joypad port controller. On each rising edge of `vblank`, when enabled through NMITIMEN bit 0, it drives the latch and clock lines of both controller ports through one 16-bit read. It shifts the pad data into the JOY1–JOY4 registers and reports a busy flag, which hvint returns as HVBJOY bit 0. It also serves manual serial access through JOYWR, JOYSER0 and JOYSER1. The block sits on the B-bus CPU register path beside hvint.

## Interface
- `STEP_CYCLES`, default 64: `clk` cycles per half-phase of latch and clock; must be ≥1.
- `clk`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-high
- `cpu_en`  in  1  CPU access strobe; qualifies `a_op` writes and read side effects
- `a_op`  in  `a_op_type`  decoded register operation
- `wdata`  in  8  CPU write data
- `rdata`  out  8  read data, combinational; 0 when `a_op` is not one of this block's codes
- `vblank`  in  1  vertical blank level from hvint
- `joy_data1`  in  2  port 1 serial data lines D1:D0, pad level, low = pressed
- `joy_data2`  in  2  port 2 serial data lines D1:D0, pad level, low = pressed
- `joy_latch`  out  1  latch to both ports, active-high
- `joy_clk1`  out  1  port 1 clock, idle high
- `joy_clk2`  out  1  port 2 clock, idle high
- `auto_busy`  out  1  auto-read in progress; hvint ORs this into HVBJOY bit 0

## Operation
- NMITIMEN write (`cpu_en`): `auto_en <= wdata[0]`.
- JOYWR write: `man_latch <= wdata[0]`.
- `joy_latch = man_latch | fsm_latch`.
- Each port clock is the AND of the FSM clock and that port's manual clock.
- JOYSER0 / JOYSER1 read:
  - returns `{6'h0, ~joy_dataN}`;
  - with `cpu_en`, drives `joy_clkN` low for exactly the next clk cycle.
- Start condition: `vblank & ~vblank_prev & auto_en & state==IDLE`. A rising edge while busy is ignored.
- FSM states and transitions:
  - IDLE → LATCH_HI (STEP) → LATCH_LO (STEP) → BIT_LO (STEP) → BIT_HI (STEP).
  - BIT_HI → BIT_LO while `bit_cnt < 15`, else → IDLE.
- Latch phase: `fsm_latch` is 1 only in LATCH_HI.
- Sampling, on the first cycle of BIT_LO:
  - each of the four shift registers shifts left and takes `~data` into bit 0;
  - JOY1 ← `joy_data1[0]`, JOY2 ← `joy_data2[0]`, JOY3 ← `joy_data1[1]`, JOY4 ← `joy_data2[1]`;
  - the first bit sampled ends in bit 15.
- Clock phase: FSM clock is low during BIT_LO and high in every other state.
- `bit_cnt` is 4 bits; it increments on BIT_HI exit.
- The JOYn registers are the shift registers themselves and are updated bitwise during the read. JOYnL = [7:0], JOYnH = [15:8].
- `auto_busy = (state != IDLE)`.
- Clearing `auto_en` mid-read does not abort; the read completes.
- Reset at any point gives:
  - state IDLE, `auto_en` = 0, `man_latch` = 0;
  - all JOYn = 16'h0;
  - `joy_latch` = 0, `joy_clk1` / `joy_clk2` = 1, `auto_busy` = 0.

## Timing
- `vblank_prev` is registered every cycle.
- LATCH_HI is entered the cycle after the rising edge is seen.
- Auto-read duration is exactly 34×STEP_CYCLES cycles of `auto_busy` high.
- Step counter:
  - width `$clog2(STEP_CYCLES+1)`;
  - reloads on each state entry;
  - a state is left when the count reaches STEP_CYCLES−1.
- Register writes take effect on the clk edge with `cpu_en`.
- `rdata` reflects current register contents in the same cycle.

## Configuration
- `AUTOJOY_MULTITAP_EN` defined:
  - the D1 lines are sampled into JOY3/JOY4;
  - JOYSER reads return both lines.
- Not defined:
  - JOY3/JOY4 read 16'h0 and their registers are omitted;
  - JOYSER read bit 1 = 0;
  - `joy_dataN[1]` is ignored.

## Structure
- Add to `bus_pkg` `a_op_type` enumerators: `A_JOYWR`, `A_JOYSER0`, `A_JOYSER1`, `A_JOY1L`, `A_JOY1H`, `A_JOY2L`, `A_JOY2H`, `A_JOY3L`, `A_JOY3H`, `A_JOY4L`, `A_JOY4H`. `A_NMITIMEN` is reused.
- Add to `bus_pkg` the FSM state enum `autojoy_state_t` (IDLE, LATCH_HI, LATCH_LO, BIT_LO, BIT_HI).
- One sub-module, `joy_port_shift`, instanced once per port: it holds the 16-bit D0 and D1 shifters for that port.

## Test plan
- `STEP_CYCLES`=2, NMITIMEN=8'h01, `joy_data1`=2'b10 constant, rising `vblank`:
  - `auto_busy` is high for exactly 68 cycles;
  - 16 `joy_clk1` low pulses;
  - JOY1 = 16'hFFFF, JOY3 = 16'h0000.
- Pad pattern low only on the first bit, D0 of port 2 → JOY2 = 16'h8000, JOY2H reads 8'h80, JOY2L reads 8'h00.
- NMITIMEN=8'h00, rising `vblank` → `auto_busy` stays 0, no latch pulse, JOYn unchanged.
- Write NMITIMEN=0 at bit 5, then a second `vblank` rise mid-read:
  - the read completes after 34×STEP;
  - no restart occurs.
- JOYWR=1 then JOYSER0 read with `joy_data1`=2'b01:
  - `joy_latch` = 1;
  - `rdata` = 8'h02;
  - `joy_clk1` is low for one cycle.
- `reset` asserted at BIT_LO of bit 7 → next cycle: IDLE, `joy_clk1` = 1, `joy_latch` = 0, JOY1 = 0, `auto_busy` = 0.
